// File: rtl/tile_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tile_ram_arbiter
//
// Shares one single-port synchronous video RAM (1-cycle read latency) between
// the tile renderer and two general-purpose client ports, A and B.
//
// The renderer owns the RAM whenever vid_busy is high. The arbiter checks
// vid_busy before it looks at client requests. In the remaining time the two
// clients are served round-robin with a req/ack handshake. Each client
// transaction takes the path IDLE -> ISSUE -> READ -> IDLE, and the ack
// pulse comes out in the IDLE cycle that follows READ.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   vid_busy, vid_addr  renderer ram_busy / ram_addr
//   a_req/a_we/a_addr/a_wdata -> a_ack/a_rdata   client A handshake
//   b_req/b_we/b_addr/b_wdata -> b_ack/b_rdata   client B handshake
//   ram_addr/ram_din/ram_we   RAM controls (combinational from state)
//   ram_dout                  RAM read data, valid the cycle after address
// -----------------------------------------------------------------------------
module tile_ram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_busy,
  input  logic [AW-1:0] vid_addr,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ, S_VIDEO} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t        r_state;
  port_t         r_last;
  port_t         r_gnt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  logic  w_a_elig;
  logic  w_b_elig;
  port_t w_pick;

  // A port's request is ignored while its own ack is high, so a client that
  // still holds req in the ack cycle does not start a second transaction.
  assign w_a_elig = a_req & ~r_a_ack;
  assign w_b_elig = b_req & ~r_b_ack;

  // On a tie the port that was not granted last wins. Otherwise the single
  // requester wins.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    w_pick = PORT_A;
    if (w_a_elig && w_b_elig) begin
      w_pick = (r_last == PORT_A) ? PORT_B : PORT_A;
    end else if (w_b_elig) begin
      w_pick = PORT_B;
    end
  end

  // The RAM controls are combinational so that the renderer's address
  // reaches the RAM with no added latency.
  always_comb begin
    ram_addr = vid_addr;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (r_state == S_ISSUE) begin
      ram_addr = r_addr;
      ram_din  = r_wdata;
      ram_we   = r_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state   <= S_IDLE;
      r_last    <= PORT_B;
      r_gnt     <= PORT_A;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (vid_busy) begin
            r_state <= S_VIDEO;
          end else if (w_a_elig || w_b_elig) begin
            // Client inputs are captured only here. Later changes cannot
            // disturb the transaction in flight.
            r_gnt   <= w_pick;
            r_last  <= w_pick;
            r_we    <= (w_pick == PORT_B) ? b_we    : a_we;
            r_addr  <= (w_pick == PORT_B) ? b_addr  : a_addr;
            r_wdata <= (w_pick == PORT_B) ? b_wdata : a_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_READ;
        S_READ: begin
          // Writes also land here. rdata then holds whatever the RAM
          // returned, and the client ignores it.
          if (r_gnt == PORT_A) begin
            r_a_rdata <= ram_dout;
            r_a_ack   <= 1'b1;
          end else begin
            r_b_rdata <= ram_dout;
            r_b_ack   <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        S_VIDEO: begin
          if (!vid_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

// File: doc/tile_ram_arbiter.md
# tile_ram_arbiter

Shares the single-port synchronous video RAM (1-cycle read latency, `RAM_sync`-style) between the tile renderer and two general-purpose client ports, A and B, such as a CPU and a blitter. The tile renderer has absolute priority while its `ram_busy` is high. Clients are served round-robin with a req/ack handshake in the remaining time. The block sits between the renderer, the clients and the RAM instance, and owns the RAM address, data-in and write-enable nets.

## Interface
Parameters:
- `AW`, default 16: RAM address width.
- `DW`, default 16: RAM data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `vid_busy`  in  1  renderer `ram_busy`; renderer owns the RAM while high.
- `vid_addr`  in  AW  renderer `ram_addr`.
- `a_req`  in  1  client A request (level).
- `a_we`  in  1  client A write (1) / read (0).
- `a_addr`  in  AW  client A address.
- `a_wdata`  in  DW  client A write data.
- `a_ack`  out  1  client A completion pulse.
- `a_rdata`  out  DW  client A read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: identical set for client B.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_dout`  in  DW  RAM read data, valid the cycle after the address.

## Operation
- FSM states:
  - IDLE: ram_addr = vid_addr, ram_we = 0.
    - If vid_busy → VIDEO. This check is evaluated before client requests.
    - Else if any eligible req → ISSUE. Latch the selected port's we/addr/wdata and record the granted port.
  - ISSUE: ram_addr/ram_din/ram_we come from the latched request. → READ unconditionally.
  - READ: ram_we = 0, ram_addr = vid_addr. Load the granted port's rdata register from ram_dout and set its ack. → IDLE.
  - VIDEO: ram_addr = vid_addr, ram_we = 0, ram_din = 0. Stay while vid_busy; → IDLE on the first cycle vid_busy is low.
- Round-robin:
  - A `last` register records the most recently granted port; reset value = B, so A wins the first tie.
  - If both ports request, grant the port ≠ `last`. If only one requests, grant it.
- Eligibility: a port's req is ignored in the cycle its own ack is high. This prevents a held req from re-issuing.
- Writes use the same ISSUE→READ path. They also get an ack. rdata is loaded with ram_dout (the old/undefined contents) and clients must not use rdata after a write.
- ram_din = latched wdata in ISSUE, otherwise 0.
- vid_busy rising during ISSUE or READ: the transaction completes normally, then the FSM enters VIDEO from IDLE. The renderer's 5-cycle busy lead guarantees completion before its first address.
- Client inputs are sampled only at grant. Changes after grant do not affect the transaction in flight.

## Timing
- Reset (async assert, sync release): state = IDLE, last = B, latched request = 0, a_ack = b_ack = 0, a_rdata = b_rdata = 0.
  - ram_addr = vid_addr, ram_din = 0, ram_we = 0 while in reset.
- Client latency, no contention, req sampled high in IDLE cycle T:
  - ISSUE in T+1: address and we on RAM.
  - READ in T+2: ram_dout valid.
  - ack high for exactly one cycle in T+3; rdata valid from T+3 and held until that port's next ack.
- Back-to-back: the minimum request-to-request spacing is 3 cycles. The earliest next grant is sampled in the T+3 IDLE cycle.
- VIDEO exit: the first cycle with vid_busy low is spent leaving VIDEO. The next IDLE cycle can grant a client.
- ram_addr, ram_din and ram_we are combinational from state and latched registers (no added latency to the renderer path). a_ack, b_ack, a_rdata and b_rdata are registered.
- Reset mid-transaction: the transaction is abandoned with no ack. ram_we drops immediately.

## Test plan
- Single read: preload mem[0x0123]=0xBEEF, a_req=1, a_we=0, a_addr=0x0123 in IDLE at T → ram_addr=0x0123 at T+1; a_ack=1 only at T+3; a_rdata=0xBEEF.
- Write then read: B writes 0x5A5A to 0x0040 → ram_we=1 only in the ISSUE cycle, b_ack one pulse; a subsequent B read of 0x0040 returns 0x5A5A.
- Contention: a_req and b_req held high continuously → grants alternate A,B,A,B with one ack every 3 cycles; no port is granted twice in a row.
- Video priority: vid_busy=1 with a_req pending → no ISSUE while busy; ram_addr tracks vid_addr each cycle and ram_we=0; A is granted on the IDLE cycle after busy drops.
- Preemption: vid_busy rises in the ISSUE cycle of an A read → A's ack and rdata still arrive at T+3, then VIDEO is entered; renderer reads 5 cycles later see correct data.
- Reset mid-ISSUE: reset low → ram_we=0, no ack; after release, last=B and the first tie is granted to A.
